multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle RV32I control unit: registered FSM sequencing the shared datapath (PC, IR, register unit, ALU, unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same control bundle as the single-cycle control unit, plus per-state write enables and a memory request/acknowledge handshake with a wait-state timeout.
- Sits between the IR/branch unit and the datapath muxes and enables.

Parameters:
- TIMEOUT, 16, max cycles MemReq may stay unacknowledged before entering ERR.
- CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- opCode  input  7  IR[6:0], stable after IRWr.
- funct3  input  3  IR[14:12].
- funct7  input  7  IR[31:25].
- BrTaken  input  1  branch unit comparison result, valid in EXEC.
- MemAck  input  1  memory completes the current request this cycle.
- MemReq  output  1  memory access request.
- DmWr  output  1  memory write; valid only with MemReq.
- DMCtrl  output  3  access size/sign, equals funct3 in MEM, 3'b010 in FETCH.
- IRWr  output  1  latch IR and OldPC.
- PCWr  output  1  write PC.
- PCSrc  output  1  0 = PC+4, 1 = ALU result.
- RUWr  output  1  register unit write.
- ALUAsrc  output  1  0 = rs1, 1 = OldPC.
- ALUBsrc  output  1  0 = rs2, 1 = immediate.
- ALUOp  output  4  ALU operation.
- ImmSrc  output  3  immediate format.
- BrOp  output  5  branch unit operation.
- RUDataWrSrc  output  2  0 = ALU, 1 = memory, 2 = PC+4.
- State  output  3  current state, for debug.
- Err  output  1  sticky fault flag.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
- Reset: next edge with rst=1 sets State=FETCH, wait counter=0, Err=0.
- While rst=1, MemReq, DmWr, IRWr, PCWr and RUWr are forced to 0; all other outputs are 0.
- Reset mid-operation abandons the instruction; no enable is asserted in the reset cycle.
- Outputs are combinational from the registered state and IR fields. MemAck is sampled in the same cycle (a zero-wait ack is legal). MemAck outside FETCH/MEM is ignored.
- Decode fields:
  - ALUOp = {funct7[5],funct3} for R-type.
  - For OP-IMM: ALUOp = {funct3==3'b101 ? funct7[5] : 0, funct3}.
  - For LUI: ALUOp = 4'b1111 (pass B).
  - Otherwise ALUOp = 4'b0000 (add).
  - ImmSrc: I=0, S=1, U=2, B=5, J=6.
  - BrOp: {2'b01,funct3} for BRANCH in EXEC, 5'b10000 for JAL/JALR, else 0.
- FETCH:
  - MemReq=1, DmWr=0.
  - On MemAck: IRWr=1, PCWr=1, PCSrc=0, go to DECODE.
- DECODE:
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode goes to ERR; otherwise go to EXEC.
- EXEC:
  - R-type and OP-IMM: go to WB.
  - LOAD/STORE: ALUBsrc=1 (address), go to MEM.
  - BRANCH: ALUAsrc=1, ALUBsrc=1; PCWr=BrTaken, PCSrc=1; go to FETCH.
  - JAL (ALUAsrc=1) and JALR (ALUAsrc=0): ALUBsrc=1, PCWr=1, PCSrc=1, go to WB.
  - LUI and AUIPC (ALUAsrc=1): ALUBsrc=1, go to WB.
- MEM:
  - MemReq=1, DmWr=1 for store, DMCtrl=funct3.
  - On MemAck: load goes to WB, store goes to FETCH.
- WB:
  - RUWr=1 for exactly one cycle, go to FETCH.
  - RUDataWrSrc = 1 for load, 2 for JAL/JALR, else 0.
- Wait counter:
  - Clears on entry to FETCH/MEM and on MemAck.
  - Increments each cycle MemReq=1 && !MemAck.
  - When it reaches TIMEOUT: go to ERR; no enable is asserted in that cycle.
- ERR: Err=1, all enables 0, MemReq=0; held until rst.
- Latency with zero-wait ack (instruction start to next FETCH):
  - R/I/U-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 4 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), MemAck tied 1 -> State 0,1,2,4,0. IRWr/PCWr high in cycle 0. RUWr high only in cycle 3 with ALUOp=0000, RUDataWrSrc=0.
- SUB (funct7=0100000) and SRAI (funct3=101, funct7[5]=1) -> ALUOp=1000 and 1101. SLLI -> ALUOp=0001.
- LW with MemAck delayed 2 cycles in FETCH and in MEM -> 9 cycles total. DMCtrl=010 in MEM, DmWr=0, RUWr once with RUDataWrSrc=1.
- BEQ -> BrOp=01000 in EXEC. With BrTaken=1: PCWr=1, PCSrc=1 in EXEC. With BrTaken=0: PCWr=0. Both return to FETCH after 3 cycles.
- MemAck held 0 in FETCH -> MemReq high 16 cycles, then State=7, Err=1, all enables 0. Only rst=1 returns to State=0 with Err=0.
- Opcode 0000000 -> ERR after DECODE. SW with rst asserted during MEM -> DmWr=0 in the reset cycle, State=0 next.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// datapath, with a memory req/ack handshake guarded by a wait-state timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opCode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       BrTaken,
  input  logic       MemAck,
  output logic       MemReq,
  output logic       DmWr,
  output logic [2:0] DMCtrl,
  output logic       IRWr,
  output logic       PCWr,
  output logic       PCSrc,
  output logic       RUWr,
  output logic       ALUAsrc,
  output logic       ALUBsrc,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [4:0] BrOp,
  output logic [1:0] RUDataWrSrc,
  output logic [2:0] State,
  output logic       Err
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ERR = 3'd7
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             tmo;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic asrc_d, bsrc_d;
  logic unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  assign is_r     = (opCode == OP_R);
  assign is_i     = (opCode == OP_I);
  assign is_ld    = (opCode == OP_LD);
  assign is_st    = (opCode == OP_ST);
  assign is_br    = (opCode == OP_BR);
  assign is_jal   = (opCode == OP_JAL);
  assign is_jalr  = (opCode == OP_JALR);
  assign is_lui   = (opCode == OP_LUI);
  assign is_auipc = (opCode == OP_AUIPC);
  assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

  // Every legal non-R op takes an immediate on B; OldPC feeds A for PC-relative ops.
  assign asrc_d = is_br | is_jal | is_lui | is_auipc;
  assign bsrc_d = ~is_r;
  assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state || MemAck) cnt <= '0;
      else if (MemReq)            cnt <= cnt + 1'b1;
      if (nxt == ERR) err_q <= 1'b1;
    end
  end

  always_comb begin
    nxt         = state;
    MemReq      = 1'b0;
    DmWr        = 1'b0;
    DMCtrl      = 3'b000;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    PCSrc       = 1'b0;
    RUWr        = 1'b0;
    ALUAsrc     = 1'b0;
    ALUBsrc     = 1'b0;
    ALUOp       = 4'b0000;
    ImmSrc      = 3'd0;
    BrOp        = 5'b00000;
    RUDataWrSrc = 2'd0;
    State       = 3'd0;
    Err         = 1'b0;
    if (!rst) begin
      State = state;
      Err   = err_q;
      if (state != ERR) begin
        if (is_r)        ALUOp = {funct7[5], funct3};
        else if (is_i)   ALUOp = {(funct3 == 3'b101) & funct7[5], funct3};
        else if (is_lui) ALUOp = 4'b1111;
        if (is_st)                   ImmSrc = 3'd1;
        else if (is_lui | is_auipc)  ImmSrc = 3'd2;
        else if (is_br)              ImmSrc = 3'd5;
        else if (is_jal)             ImmSrc = 3'd6;
      end
      // The ALU is combinational, so operand selects are held until writeback.
      if (state == EXEC || state == MEM || state == WB) begin
        ALUAsrc = asrc_d;
        ALUBsrc = bsrc_d;
      end
      unique case (state)
        FETCH: begin
          MemReq = 1'b1;
          DMCtrl = 3'b010;
          if (MemAck) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
            nxt  = DECODE;
          end else if (tmo) nxt = ERR;
        end
        DECODE: nxt = legal ? EXEC : ERR;
        EXEC: begin
          if (is_br) begin
            BrOp  = {2'b01, funct3};
            PCWr  = BrTaken;
            PCSrc = 1'b1;
            nxt   = FETCH;
          end else if (is_jal | is_jalr) begin
            BrOp  = 5'b10000;
            PCWr  = 1'b1;
            PCSrc = 1'b1;
            nxt   = WB;
          end else if (is_ld | is_st) nxt = MEM;
          else                         nxt = WB;
        end
        MEM: begin
          MemReq = 1'b1;
          DmWr   = is_st;
          DMCtrl = funct3;
          if (MemAck)   nxt = is_st ? FETCH : WB;
          else if (tmo) nxt = ERR;
        end
        WB: begin
          RUWr = 1'b1;
          if (is_ld)                 RUDataWrSrc = 2'd1;
          else if (is_jal | is_jalr) RUDataWrSrc = 2'd2;
          nxt = FETCH;
        end
        ERR:     nxt = ERR;
        default: nxt = ERR;
      endcase
    end
  end
endmodule
